// File: rtl/arbitro_memoria.sv
// ---------------------------------------------------------------------------
// arbitro_memoria
//   Two-master arbiter in front of a single main-memory port. The CPU and the
//   disk loader (HD) share the memory; one access is served at a time through
//   a three-state sequence IDLE -> SERVE -> ACK. When both masters request in
//   the same IDLE cycle, the one that was not served last wins.
//
// Optional feature (macro ARB_BOUNDS_CHECK_EN):
//   When defined, an access whose bank (addr[15:8]) is >= MEM_BANKS or whose
//   offset (addr[7:0]) is >= MEM_WORDS is not issued to memory. The winner
//   gets ack together with err, and its rdata is loaded with zero.
//   When undefined, every address is forwarded and cpu_err/hd_err stay low.
//
// Parameters:
//   MEM_BANKS  number of memory banks (address bits [15:8])
//   MEM_WORDS  words per bank (address bits [7:0])
//
// Ports:
//   clk, reset            clock (rising edge), asynchronous active-high reset
//   cpu_req, cpu_we       CPU request and write enable
//   cpu_addr, cpu_wdata   CPU physical address {bank,offset} and write data
//   cpu_ack, cpu_err      CPU completion pulse and error flag
//   cpu_rdata             CPU read data (registered)
//   hd_req, hd_we         disk-loader request and write enable
//   hd_addr, hd_wdata     disk-loader offset (bits [7:0]) and write data
//   hd_set                disk-loader partition, used as the bank number
//   hd_ack, hd_err        disk-loader completion pulse and error flag
//   hd_rdata              disk-loader read data (registered)
//   mem_ctrl              memory control: 2'b01 write, 2'b00 otherwise
//   mem_addr, mem_store   memory address and store data (valid in SERVE)
//   mem_rdata             memory read data
// ---------------------------------------------------------------------------
module arbitro_memoria #(
  parameter int MEM_BANKS = 8,
  parameter int MEM_WORDS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic        cpu_ack,
  output logic        cpu_err,
  output logic [15:0] cpu_rdata,
  input  logic        hd_req,
  input  logic        hd_we,
  input  logic [15:0] hd_addr,
  input  logic [15:0] hd_wdata,
  input  logic [2:0]  hd_set,
  output logic        hd_ack,
  output logic        hd_err,
  output logic [15:0] hd_rdata,
  output logic [1:0]  mem_ctrl,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_store,
  input  logic [15:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    ACK   = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;

  // Transaction captured when leaving IDLE; inputs are ignored afterwards.
  logic        last_hd;
  logic        win_hd;
  logic        lat_we;
  logic [15:0] lat_addr;
  logic [15:0] lat_data;

  // Candidate transaction, evaluated every IDLE cycle.
  logic        pick_hd;
  logic        pick_we;
  logic [15:0] pick_addr;
  logic [15:0] pick_data;

  logic        addr_err;

  // The disk loader only supplies an offset; its bank comes from hd_set,
  // so the upper byte of hd_addr is deliberately ignored.
  logic [7:0]  unused_hd_addr_hi;
  assign unused_hd_addr_hi = hd_addr[15:8];

`ifdef ARB_BOUNDS_CHECK_EN
  // One extra bit so a limit of 256 banks/words still compares correctly.
  localparam logic [8:0] BANK_LIMIT = 9'(MEM_BANKS);
  localparam logic [8:0] WORD_LIMIT = 9'(MEM_WORDS);

  assign addr_err = ({1'b0, lat_addr[15:8]} >= BANK_LIMIT) ||
                    ({1'b0, lat_addr[7:0]}  >= WORD_LIMIT);
`else
  // Sizes only matter when the bounds check is built in.
  logic [63:0] unused_sizes;
  assign unused_sizes = {32'(MEM_BANKS), 32'(MEM_WORDS)};
  assign addr_err     = 1'b0;
`endif

  // Winner selection: a lone requester wins; on a tie the master that was
  // not served last wins (last_hd=1 means the CPU gets the tie).
  always_comb begin
    pick_hd   = hd_req && (!cpu_req || !last_hd);
    pick_we   = pick_hd ? hd_we : cpu_we;
    pick_addr = pick_hd ? {5'b0, hd_set, hd_addr[7:0]} : cpu_addr;
    pick_data = pick_hd ? hd_wdata : cpu_wdata;
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state: requests are only looked at in IDLE.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (cpu_req || hd_req) state_next = SERVE;
      SERVE:   state_next = ACK;
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Transaction latch, round-robin history and registered responses. The
  // ack/err flags are single-cycle pulses that line up with the ACK state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_hd   <= 1'b1;
      win_hd    <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_data  <= '0;
      cpu_ack   <= 1'b0;
      cpu_err   <= 1'b0;
      cpu_rdata <= '0;
      hd_ack    <= 1'b0;
      hd_err    <= 1'b0;
      hd_rdata  <= '0;
    end else begin
      cpu_ack <= 1'b0;
      cpu_err <= 1'b0;
      hd_ack  <= 1'b0;
      hd_err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cpu_req || hd_req) begin
            win_hd   <= pick_hd;
            lat_we   <= pick_we;
            lat_addr <= pick_addr;
            lat_data <= pick_data;
          end
        end
        SERVE: begin
          last_hd <= win_hd;
          if (win_hd) begin
            hd_ack <= 1'b1;
            hd_err <= addr_err;
            if (addr_err)     hd_rdata <= '0;
            else if (!lat_we) hd_rdata <= mem_rdata;
          end else begin
            cpu_ack <= 1'b1;
            cpu_err <= addr_err;
            if (addr_err)     cpu_rdata <= '0;
            else if (!lat_we) cpu_rdata <= mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  // Memory port: only active in SERVE. A rejected access keeps mem_ctrl
  // idle so nothing is written.
  always_comb begin
    mem_ctrl  = 2'b00;
    mem_addr  = '0;
    mem_store = '0;
    if (state == SERVE) begin
      mem_addr  = lat_addr;
      mem_store = lat_data;
      if (lat_we && !addr_err) mem_ctrl = 2'b01;
    end
  end

endmodule

// File: tb/tb_arbitro_memoria.sv
// ---------------------------------------------------------------------------
// tb_arbitro_memoria
//   Self-checking bench for arbitro_memoria. A simple memory array stands in
//   for main memory; a transaction-level reference (expected memory contents,
//   expected rdata registers, which master was served last) predicts every
//   observed value. Directed scenarios are followed by a random mix.
// ---------------------------------------------------------------------------
module tb_arbitro_memoria;

  localparam int NB = 8;
  localparam int NW = 8;
`ifdef ARB_BOUNDS_CHECK_EN
  localparam bit BOUNDS_ON = 1'b1;
`else
  localparam bit BOUNDS_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [15:0] cpu_addr, cpu_wdata;
  logic        cpu_ack, cpu_err;
  logic [15:0] cpu_rdata;
  logic        hd_req, hd_we;
  logic [15:0] hd_addr, hd_wdata;
  logic [2:0]  hd_set;
  logic        hd_ack, hd_err;
  logic [15:0] hd_rdata;
  logic [1:0]  mem_ctrl;
  logic [15:0] mem_addr, mem_store, mem_rdata;

  int checks = 0;
  int errors = 0;

  // Main memory stand-in: combinational read, write on clock when enabled.
  logic [15:0] mem_array [0:65535];

  // Reference: expected memory image and expected registered read data.
  typedef enum {SERVED_CPU, SERVED_HD} served_t;
  logic [15:0] ref_mem [int];
  logic [15:0] exp_cpu_rdata;
  logic [15:0] exp_hd_rdata;
  served_t     prev_served;

  arbitro_memoria #(.MEM_BANKS(NB), .MEM_WORDS(NW)) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_ack   (cpu_ack),
    .cpu_err   (cpu_err),
    .cpu_rdata (cpu_rdata),
    .hd_req    (hd_req),
    .hd_we     (hd_we),
    .hd_addr   (hd_addr),
    .hd_wdata  (hd_wdata),
    .hd_set    (hd_set),
    .hd_ack    (hd_ack),
    .hd_err    (hd_err),
    .hd_rdata  (hd_rdata),
    .mem_ctrl  (mem_ctrl),
    .mem_addr  (mem_addr),
    .mem_store (mem_store),
    .mem_rdata (mem_rdata)
  );

  // 10-unit clock.
  always #5 clk = ~clk;

  // Memory stand-in behaviour.
  initial begin
    for (int i = 0; i < 65536; i++) mem_array[i] = 16'h0000;
  end

  assign mem_rdata = mem_array[mem_addr];

  always @(posedge clk) begin
    if (mem_ctrl == 2'b01) mem_array[mem_addr] <= mem_store;
  end

  // One comparison: counts it, and on mismatch counts and reports it.
  task automatic check_output(input string tag, input logic [15:0] obs,
                              input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete transaction, started at a negedge with the arbiter idle.
  // The reference decides the winner, the physical address and whether the
  // access is out of range, then every phase is compared. Inputs are
  // scrambled during SERVE to show they are ignored, and requests are held
  // until the following idle cycle, where they are released.
  task automatic apply_stimulus(
    input  bit          c_req, input bit c_we,
    input  logic [15:0] c_addr, input logic [15:0] c_data,
    input  logic [15:0] c_addr_late,
    input  bit          h_req, input bit h_we,
    input  logic [15:0] h_addr, input logic [15:0] h_data,
    input  logic [2:0]  h_set,
    output bit          got_hd);
    bit          exp_hd, we, bad;
    int          phys;
    logic [15:0] data, exp_rd;
    logic [1:0]  exp_ctrl;

    if (c_req && h_req) exp_hd = (prev_served == SERVED_CPU);
    else                exp_hd = h_req;
    phys = exp_hd ? (int'(h_set) * 256 + int'(h_addr) % 256) : int'(c_addr);
    we   = exp_hd ? h_we : c_we;
    data = exp_hd ? h_data : c_data;
    bad  = BOUNDS_ON && ((phys / 256) >= NB || (phys % 256) >= NW);
    exp_ctrl = (we && !bad) ? 2'b01 : 2'b00;
    exp_rd   = bad ? 16'h0000 : (ref_mem.exists(phys) ? ref_mem[phys] : 16'h0000);

    cpu_req = c_req; cpu_we = c_we; cpu_addr = c_addr; cpu_wdata = c_data;
    hd_req  = h_req; hd_we  = h_we; hd_addr  = h_addr; hd_wdata  = h_data;
    hd_set  = h_set;

    @(posedge clk); @(negedge clk);
    check_output("serve_ctrl",  {14'b0, mem_ctrl}, {14'b0, exp_ctrl});
    check_output("serve_addr",  mem_addr, phys[15:0]);
    check_output("serve_store", mem_store, data);
    check_output("serve_noack", {14'b0, cpu_ack, hd_ack}, 16'h0000);

    cpu_addr = c_addr_late; cpu_wdata = ~c_data; cpu_we = ~c_we;
    hd_addr  = ~h_addr;     hd_wdata  = ~h_data; hd_set = ~h_set;

    @(posedge clk); @(negedge clk);
    if (!we || bad) begin
      if (exp_hd) exp_hd_rdata  = exp_rd;
      else        exp_cpu_rdata = exp_rd;
    end
    if (we && !bad) ref_mem[phys] = data;
    prev_served = exp_hd ? SERVED_HD : SERVED_CPU;

    check_output("ack_pair", {14'b0, cpu_ack, hd_ack},
                 exp_hd ? 16'h0001 : 16'h0002);
    check_output("err_pair", {14'b0, cpu_err, hd_err},
                 bad ? (exp_hd ? 16'h0001 : 16'h0002) : 16'h0000);
    check_output("cpu_rdata", cpu_rdata, exp_cpu_rdata);
    check_output("hd_rdata",  hd_rdata,  exp_hd_rdata);
    check_output("ack_ctrl",  {14'b0, mem_ctrl}, 16'h0000);
    got_hd = hd_ack;

    @(posedge clk); @(negedge clk);
    check_output("idle_noack", {14'b0, cpu_ack, hd_ack}, 16'h0000);
    check_output("idle_addr",  mem_addr, 16'h0000);
    cpu_req = 1'b0;
    hd_req  = 1'b0;
  endtask

  // Directed scenarios followed by a random mix.
  initial begin
    bit          got;
    bit          exp_order [4];
    int          lim, sel;
    logic [15:0] ca, ha, cd, hdd, late;

    reset = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    hd_req  = 1'b0; hd_we  = 1'b0; hd_addr  = '0; hd_wdata  = '0; hd_set = '0;
    exp_cpu_rdata = '0;
    exp_hd_rdata  = '0;
    prev_served   = SERVED_HD;
    exp_order[0] = 1'b0; exp_order[1] = 1'b1;
    exp_order[2] = 1'b0; exp_order[3] = 1'b1;

    // Reset values, observed before any clock edge.
    #1;
    check_output("rst_acks",  {14'b0, cpu_ack, hd_ack}, 16'h0000);
    check_output("rst_errs",  {14'b0, cpu_err, hd_err}, 16'h0000);
    check_output("rst_cpu_rdata", cpu_rdata, 16'h0000);
    check_output("rst_hd_rdata",  hd_rdata,  16'h0000);
    check_output("rst_ctrl",  {14'b0, mem_ctrl}, 16'h0000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Both masters request continuously from reset: CPU, HD, CPU, HD.
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1'b1, 1'b0, 16'h0000, 16'h0C0C, 16'h0000,
                     1'b1, 1'b0, 16'h0002, 16'h0D0D, 3'd1, got);
      check_output("rr_order", {15'b0, got}, {15'b0, exp_order[i]});
    end

    // CPU write then read back.
    apply_stimulus(1'b1, 1'b1, 16'h0203, 16'hBEEF, 16'h0203,
                   1'b0, 1'b0, 16'h0000, 16'h0000, 3'd0, got);
    apply_stimulus(1'b1, 1'b0, 16'h0203, 16'h0000, 16'h0203,
                   1'b0, 1'b0, 16'h0000, 16'h0000, 3'd0, got);
    check_output("cpu_readback", cpu_rdata, 16'hBEEF);

    // Disk loader write relocated to partition 5, read back by the CPU.
    apply_stimulus(1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000,
                   1'b1, 1'b1, 16'hA704, 16'h1234, 3'd5, got);
    apply_stimulus(1'b1, 1'b0, 16'h0504, 16'h0000, 16'h0504,
                   1'b0, 1'b0, 16'h0000, 16'h0000, 3'd0, got);
    check_output("hd_reloc_read", cpu_rdata, 16'h1234);

    // Address change during SERVE must not affect the access.
    apply_stimulus(1'b1, 1'b1, 16'h0102, 16'h1111, 16'h0102,
                   1'b0, 1'b0, 16'h0000, 16'h0000, 3'd0, got);
    apply_stimulus(1'b1, 1'b1, 16'h0300, 16'h3333, 16'h0300,
                   1'b0, 1'b0, 16'h0000, 16'h0000, 3'd0, got);
    apply_stimulus(1'b1, 1'b0, 16'h0102, 16'h0000, 16'h0300,
                   1'b0, 1'b0, 16'h0000, 16'h0000, 3'd0, got);
    check_output("late_addr_read", cpu_rdata, 16'h1111);

    // Reset in the middle of a write aborts it.
    apply_stimulus(1'b1, 1'b1, 16'h0101, 16'h5555, 16'h0101,
                   1'b0, 1'b0, 16'h0000, 16'h0000, 3'd0, got);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0101; cpu_wdata = 16'hAAAA;
    @(posedge clk); @(negedge clk);
    check_output("abort_serve_ctrl", {14'b0, mem_ctrl}, 16'h0001);
    reset = 1'b1;
    #1;
    check_output("abort_ctrl", {14'b0, mem_ctrl}, 16'h0000);
    check_output("abort_addr", mem_addr, 16'h0000);
    check_output("abort_noack", {14'b0, cpu_ack, hd_ack}, 16'h0000);
    @(posedge clk); @(negedge clk);
    reset = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
    exp_cpu_rdata = '0;
    exp_hd_rdata  = '0;
    prev_served   = SERVED_HD;
    check_output("abort_rdata", cpu_rdata, 16'h0000);
    @(posedge clk); @(negedge clk);
    check_output("abort_after_noack", {14'b0, cpu_ack, hd_ack}, 16'h0000);
    check_output("abort_mem_kept", mem_array[16'h0101], 16'h5555);
    apply_stimulus(1'b1, 1'b0, 16'h0101, 16'h0000, 16'h0101,
                   1'b0, 1'b0, 16'h0000, 16'h0000, 3'd0, got);
    check_output("abort_readback", cpu_rdata, 16'h5555);

    // Offset 9 is outside a bank only when the bounds check is built in.
    apply_stimulus(1'b1, 1'b0, 16'h0009, 16'h0000, 16'h0009,
                   1'b0, 1'b0, 16'h0000, 16'h0000, 3'd0, got);
    check_output("oob_err", {15'b0, cpu_err}, {15'b0, BOUNDS_ON});

    // Random mix of lone and competing requests.
    lim = BOUNDS_ON ? 9 : 7;
    for (int n = 0; n < 40; n++) begin
      sel  = $urandom_range(0, 2);
      ca   = {8'($urandom_range(0, lim)), 8'($urandom_range(0, lim))};
      ha   = {8'($urandom), 8'($urandom_range(0, lim))};
      cd   = 16'($urandom);
      hdd  = 16'($urandom);
      late = 16'($urandom);
      apply_stimulus(sel != 1, 1'($urandom), ca, cd, late,
                     sel != 0, 1'($urandom), ha, hdd, 3'($urandom), got);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
